// File: rtl/fb_draw_scheduler_pkg.sv
// fb_draw_scheduler_pkg: shared state encoding, pixel defaults and sizing helper for the draw scheduler
package fb_draw_scheduler_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, READY} fb_state_e;
  localparam int PIX_W_DEF = 5;
  localparam logic [PIX_W_DEF-1:0] BG_COLOR_DEF = 5'd0;
  localparam logic [PIX_W_DEF-1:0] TRANSP_DEF = 5'd31;
  localparam int COORD_W = 10;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fb_draw_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request after the pointer
module rr_arbiter
  import fb_draw_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] winner,
  output logic             any
);
  logic [IDX_W-1:0] idx;
  always_comb begin
    grant = '0;
    winner = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!any && req[idx]) begin
        any = 1'b1;
        grant[idx] = 1'b1;
        winner = idx;
      end
    end
  end
endmodule

// File: rtl/fb_draw_scheduler.sv
// fb_draw_scheduler: per-frame clear/draw sequencer sharing one frame-buffer write port between sprite requesters
module fb_draw_scheduler
  import fb_draw_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int FB_W = 320,
  parameter int FB_H = 240,
  parameter int PIX_W = PIX_W_DEF,
  parameter logic [PIX_W-1:0] BG_COLOR = PIX_W'(BG_COLOR_DEF),
  parameter logic [PIX_W-1:0] TRANSP = PIX_W'(TRANSP_DEF),
  parameter int ADDR_W = $clog2(FB_W * FB_H)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     VS,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*COORD_W-1:0] req_x,
  input  logic [N_REQ*COORD_W-1:0] req_y,
  input  logic [N_REQ*PIX_W-1:0]   req_pix,
  input  logic [N_REQ-1:0]         req_done,
  output logic [N_REQ-1:0]         grant,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [PIX_W-1:0]         wr_data,
  output logic                     front_sel,
  output logic                     frame_busy,
  output logic                     overrun
);
  localparam int IDX_W = idx_w(N_REQ);
  localparam int N_PIX = FB_W * FB_H;
  fb_state_e state, next_state;
  logic vs_q;
  logic vs_fall;
  logic [ADDR_W-1:0] clr_cnt;
  logic clr_last;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic [N_REQ-1:0] arb_grant;
  logic any;
  logic [COORD_W-1:0] sel_x;
  logic [COORD_W-1:0] sel_y;
  logic [PIX_W-1:0] sel_pix;
  int lin_addr;
  logic draw_wr;
  logic nxt_en;
  logic [ADDR_W-1:0] nxt_addr;
  logic [PIX_W-1:0] nxt_data;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req(req),
    .ptr(ptr),
    .grant(arb_grant),
    .winner(winner),
    .any(any)
  );

  assign vs_fall = vs_q & ~VS;
  assign clr_last = clr_cnt == ADDR_W'(N_PIX - 1);
  assign sel_x = req_x[COORD_W*winner +: COORD_W];
  assign sel_y = req_y[COORD_W*winner +: COORD_W];
  assign sel_pix = req_pix[PIX_W*winner +: PIX_W];
  assign lin_addr = int'(sel_y) * FB_W + int'(sel_x);
  assign draw_wr = any && int'(sel_x) < FB_W && int'(sel_y) < FB_H && sel_pix != TRANSP;

  always_ff @(posedge Clk) state <= Reset ? IDLE : next_state;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = vs_fall ? CLEAR : IDLE;
      CLEAR: next_state = clr_last ? DRAW : CLEAR;
      DRAW: next_state = (&req_done && req == '0) ? READY : DRAW;
      READY: next_state = vs_fall ? CLEAR : READY;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    grant = state == DRAW ? arb_grant : '0;
    frame_busy = state == CLEAR || state == DRAW;
    nxt_en = state == CLEAR || (state == DRAW && draw_wr);
    nxt_addr = state == CLEAR ? clr_cnt : (nxt_en ? ADDR_W'(lin_addr) : '0);
    nxt_data = state == CLEAR ? BG_COLOR : (nxt_en ? sel_pix : '0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_q <= 1'b1;
      clr_cnt <= '0;
      ptr <= IDX_W'(N_REQ - 1);
      front_sel <= 1'b0;
      overrun <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      vs_q <= VS;
      clr_cnt <= state == CLEAR ? (clr_last ? '0 : clr_cnt + 1'b1) : clr_cnt;
      ptr <= state == DRAW && any ? winner : ptr;
      front_sel <= state == READY && vs_fall ? ~front_sel : front_sel;
      overrun <= vs_fall && frame_busy;
      wr_en <= nxt_en;
      wr_addr <= nxt_addr;
      wr_data <= nxt_data;
    end
  end
endmodule

// File: tb/tb_fb_draw_scheduler.sv
// tb_fb_draw_scheduler: randomized and directed check of the draw scheduler against a frame-level model
module tb_fb_draw_scheduler;
  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 4;
  localparam int PW = 5;
  localparam int AW = $clog2(W * H);
  localparam int BG = 0;
  localparam int TR = 31;
  localparam int P_IDLE = 0;
  localparam int P_CLEAR = 1;
  localparam int P_DRAW = 2;
  localparam int P_READY = 3;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic VS = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] req_done = '0;
  logic [N*10-1:0] req_x = '0;
  logic [N*10-1:0] req_y = '0;
  logic [N*PW-1:0] req_pix = '0;
  logic [N-1:0] grant;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic front_sel;
  logic frame_busy;
  logic overrun;
  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;
  int ph = P_IDLE;
  int clr = 0;
  int ptr = N - 1;
  int front = 0;
  int vsq = 1;
  int ew = 0;
  int ea = 0;
  int ed = 0;
  int eo = 0;
  int wt[N];
  int maxw = 0;

  fb_draw_scheduler #(.N_REQ(N), .FB_W(W), .FB_H(H)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .VS(VS),
    .req(req),
    .req_x(req_x),
    .req_y(req_y),
    .req_pix(req_pix),
    .req_done(req_done),
    .grant(grant),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .front_sel(front_sel),
    .frame_busy(frame_busy),
    .overrun(overrun)
  );

  always #10 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge Clk) begin
    int g;
    int x;
    int y;
    int p;
    bit fall;
    if (Reset) begin
      ph = P_IDLE;
      clr = 0;
      ptr = N - 1;
      front = 0;
      vsq = 1;
      ew = 0;
      ea = 0;
      ed = 0;
      eo = 0;
    end else begin
      fall = vsq == 1 && VS == 1'b0;
      ew = 0;
      ea = 0;
      ed = 0;
      eo = (fall && (ph == P_CLEAR || ph == P_DRAW)) ? 1 : 0;
      if (ph == P_IDLE) begin
        if (fall) ph = P_CLEAR;
      end else if (ph == P_CLEAR) begin
        ew = 1;
        ea = clr;
        ed = BG;
        if (clr == W * H - 1) begin
          clr = 0;
          ph = P_DRAW;
        end else clr++;
      end else if (ph == P_DRAW) begin
        g = pick(req, ptr);
        if (g >= 0) begin
          ptr = g;
          x = int'(req_x[g*10 +: 10]);
          y = int'(req_y[g*10 +: 10]);
          p = int'(req_pix[g*PW +: PW]);
          if (x < W && y < H && p != TR) begin
            ew = 1;
            ea = y * W + x;
            ed = p;
          end
        end
        if (req_done == '1 && req == '0) ph = P_READY;
      end else if (fall) begin
        front = 1 - front;
        ph = P_CLEAR;
      end
      vsq = VS ? 1 : 0;
    end
  end

  always @(negedge Clk) begin
    int g;
    if (chk_on) begin
      g = pick(req, ptr);
      chk("grant", grant, (ph == P_DRAW && g >= 0) ? (1 << g) : 0);
      chk("wr_en", wr_en, ew);
      if (ew == 1) begin
        chk("wr_addr", wr_addr, ea);
        chk("wr_data", wr_data, ed);
      end
      chk("front_sel", front_sel, front);
      chk("frame_busy", frame_busy, (ph == P_CLEAR || ph == P_DRAW) ? 1 : 0);
      chk("overrun", overrun, eo);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic vs_pulse();
    VS = 1'b0;
    step();
    VS = 1'b1;
  endtask

  task automatic set_req(input int i, input int x, input int y, input int p);
    req_x[i*10 +: 10] = 10'(x);
    req_y[i*10 +: 10] = 10'(y);
    req_pix[i*PW +: PW] = PW'(p);
  endtask

  task automatic rand_cycles(input int n, input int vs_at);
    logic [N-1:0] gs;
    for (int c = 0; c < n; c++) begin
      @(negedge Clk);
      gs = grant;
      for (int i = 0; i < N; i++) begin
        if (ph == P_DRAW && req[i]) wt[i] = gs[i] ? 0 : wt[i] + 1;
        else wt[i] = 0;
        if (wt[i] > maxw) maxw = wt[i];
      end
      step();
      VS = (c == vs_at) ? 1'b0 : 1'b1;
      for (int i = 0; i < N; i++) begin
        if (!req[i] || gs[i]) begin
          req[i] = $urandom_range(0, 2) != 0;
          set_req(i, int'($urandom_range(0, 9)), int'($urandom_range(0, 5)), int'($urandom_range(0, 31)));
        end
      end
    end
    VS = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) wt[i] = 0;
    step();
    chk_on = 1'b1;
    step();
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_front", front_sel, 0);
    chk("rst_busy", frame_busy, 0);
    chk("rst_grant", grant, 0);
    vs_pulse();
    step();
    for (int k = 0; k < W * H; k++) begin
      @(negedge Clk);
      chk("clr_en", wr_en, 1);
      chk("clr_addr", wr_addr, k);
      chk("clr_data", wr_data, BG);
      step();
    end
    @(negedge Clk);
    chk("clr_end", wr_en, 0);
    chk("draw_busy", frame_busy, 1);
    step();
    req = '1;
    for (int i = 0; i < N; i++) set_req(i, i, 1, i + 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      chk("rr_grant", grant, 1 << (k % N));
      if (k > 0) chk("rr_addr", wr_addr, W + (k - 1) % N);
      step();
    end
    req = 4'b0001;
    set_req(0, 3, 2, 7);
    @(negedge Clk);
    chk("one_grant", grant, 1);
    step();
    req = '0;
    @(negedge Clk);
    chk("one_wr_en", wr_en, 1);
    chk("one_addr", wr_addr, 19);
    chk("one_data", wr_data, 7);
    step();
    req = 4'b0001;
    set_req(0, 3, 2, TR);
    @(negedge Clk);
    chk("transp_grant", grant, 1);
    step();
    req = '0;
    @(negedge Clk);
    chk("transp_no_wr", wr_en, 0);
    step();
    req = 4'b0001;
    set_req(0, W, 2, 7);
    @(negedge Clk);
    chk("xoob_grant", grant, 1);
    step();
    req = '0;
    @(negedge Clk);
    chk("xoob_no_wr", wr_en, 0);
    step();
    rand_cycles(600, 300);
    req = '0;
    step();
    vs_pulse();
    @(negedge Clk);
    chk("ovr_pulse", overrun, 1);
    chk("ovr_front", front_sel, 0);
    chk("ovr_busy", frame_busy, 1);
    step();
    @(negedge Clk);
    chk("ovr_once", overrun, 0);
    step();
    req_done = '1;
    step();
    @(negedge Clk);
    chk("ready_busy", frame_busy, 0);
    step();
    vs_pulse();
    req_done = '0;
    @(negedge Clk);
    chk("swap_front", front_sel, 1);
    chk("swap_busy", frame_busy, 1);
    chk("swap_no_ovr", overrun, 0);
    step();
    @(negedge Clk);
    chk("reclr_en", wr_en, 1);
    chk("reclr_addr", wr_addr, 0);
    step();
    rand_cycles(80, -1);
    total++;
    if (maxw >= N) begin
      bad++;
      $display("FAIL starvation: waited %0d cycles, limit %0d", maxw, N - 1);
    end
    req = '1;
    Reset = 1'b1;
    step();
    step();
    @(negedge Clk);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_addr", wr_addr, 0);
    chk("mid_rst_data", wr_data, 0);
    chk("mid_rst_front", front_sel, 0);
    chk("mid_rst_busy", frame_busy, 0);
    chk("mid_rst_ovr", overrun, 0);
    step();
    Reset = 1'b0;
    req = '0;
    step();
    @(negedge Clk);
    chk("idle_after_rst", frame_busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
